// File: rtl/alu_pkg.sv
// Definitions shared by the ALU issuer: opcode encodings, opcode legality and issuer FSM states.
package alu_pkg;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_ROTR  = 4'b0010;
    localparam logic [3:0] OP_MUL   = 4'b0100;
    localparam logic [3:0] OP_LOGIC = 4'b0110;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        DRIVE = 2'b01,
        RESP  = 2'b10
    } issuer_state_e;

    // True only for opcodes the ALU implements; anything else is answered with an error response.
    function automatic logic op_legal(input logic [3:0] op);
        logic legal_s;
        case (op)
            OP_ADD, OP_SUB, OP_ROTR, OP_MUL, OP_LOGIC: legal_s = 1'b1;
            default:                                   legal_s = 1'b0;
        endcase
        return legal_s;
    endfunction

endpackage

// File: rtl/alu_op_issuer.sv
// Initiator for the 8-bit combinational ALU: takes commands on a valid/ready stream,
// holds registered operands for a settle window, captures Z/FLAGS and returns them on
// a valid/ready response stream. Keeps an accumulator so commands can chain results.
module alu_op_issuer
    import alu_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [7:0]       cmd_a,
    input  logic [7:0]       cmd_b,
    input  logic             cmd_use_acc,
    output logic [3:0]       alu_ctl,
    output logic [7:0]       alu_a,
    output logic [7:0]       alu_b,
    input  logic [7:0]       alu_z,
    input  logic [7:0]       alu_flags,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [7:0]       rsp_z,
    output logic [7:0]       rsp_flags,
    output logic             rsp_err,
    output logic [7:0]       acc,
    output logic [CNT_W-1:0] op_count
);

    // Counter is loaded with SETTLE_CYCLES-1 and counts down to zero.
    localparam int SCNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SCNT_W-1:0] SETTLE_LOAD = SCNT_W'(SETTLE_CYCLES - 1);
    localparam logic [SCNT_W-1:0] SETTLE_ZERO = SCNT_W'(1'b0);
    localparam logic [SCNT_W-1:0] SETTLE_ONE  = SCNT_W'(1'b1);
    localparam logic [CNT_W-1:0]  COUNT_ONE   = CNT_W'(1'b1);

    issuer_state_e     state_r;
    issuer_state_e     state_nxt_s;
    logic              accept_s;
    logic              capture_s;
    logic              legal_s;
    logic [SCNT_W-1:0] settle_cnt_r;

    logic              cmd_ready_r;
    logic              rsp_valid_r;
    logic [3:0]        alu_ctl_r;
    logic [7:0]        alu_a_r;
    logic [7:0]        alu_b_r;
    logic [7:0]        rsp_z_r;
    logic [7:0]        rsp_flags_r;
    logic              rsp_err_r;
    logic [7:0]        acc_r;
    logic [CNT_W-1:0]  op_count_r;

    assign legal_s = op_legal(cmd_op);

    // Next-state logic plus the single-cycle accept/capture strobes.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        capture_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (cmd_valid) begin
                    accept_s = 1'b1;
                    if (legal_s) begin
                        state_nxt_s = DRIVE;
                    end else begin
                        state_nxt_s = RESP;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            DRIVE: begin
                if (settle_cnt_r == SETTLE_ZERO) begin
                    capture_s   = 1'b1;
                    state_nxt_s = RESP;
                end else begin
                    state_nxt_s = DRIVE;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Handshake outputs registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
        end else begin
            cmd_ready_r <= (state_nxt_s == IDLE);
            rsp_valid_r <= (state_nxt_s == RESP);
        end
    end

    // Operand/opcode registers toward the ALU (held between operations) and the settle countdown.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_ctl_r    <= 4'b0000;
            alu_a_r      <= 8'h00;
            alu_b_r      <= 8'h00;
            settle_cnt_r <= SETTLE_ZERO;
        end else if (accept_s && legal_s) begin
            alu_ctl_r    <= cmd_op;
            alu_a_r      <= cmd_use_acc ? acc_r : cmd_a;
            alu_b_r      <= cmd_b;
            settle_cnt_r <= SETTLE_LOAD;
        end else if ((state_r == DRIVE) && (settle_cnt_r != SETTLE_ZERO)) begin
            settle_cnt_r <= settle_cnt_r - SETTLE_ONE;
        end
    end

    // Response capture; accumulator and counter move only when a legal operation completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_z_r     <= 8'h00;
            rsp_flags_r <= 8'h00;
            rsp_err_r   <= 1'b0;
            acc_r       <= 8'h00;
            op_count_r  <= {CNT_W{1'b0}};
        end else if (accept_s && !legal_s) begin
            rsp_z_r     <= 8'h00;
            rsp_flags_r <= 8'h00;
            rsp_err_r   <= 1'b1;
        end else if (capture_s) begin
            rsp_z_r     <= alu_z;
            rsp_flags_r <= alu_flags;
            rsp_err_r   <= 1'b0;
            acc_r       <= alu_z;
            op_count_r  <= op_count_r + COUNT_ONE;
        end
    end

    assign cmd_ready = cmd_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign alu_ctl   = alu_ctl_r;
    assign alu_a     = alu_a_r;
    assign alu_b     = alu_b_r;
    assign rsp_z     = rsp_z_r;
    assign rsp_flags = rsp_flags_r;
    assign rsp_err   = rsp_err_r;
    assign acc       = acc_r;
    assign op_count  = op_count_r;

endmodule

// File: tb/tb_alu_op_issuer.sv
// Bench for alu_op_issuer: two instances (SETTLE=1/CNT_W=8 and SETTLE=3/CNT_W=2), each
// wired to a behavioural ALU, driven with directed and random commands and checked
// against a transaction-level model of the issuer.
module tb_alu_op_issuer;
    import alu_pkg::*;

    localparam int S0 = 1;
    localparam int S1 = 3;

    logic clk;
    logic [1:0]      rst, cmd_valid, cmd_ready, cmd_use_acc, rsp_valid, rsp_ready, rsp_err;
    logic [1:0][3:0] cmd_op, alu_ctl;
    logic [1:0][7:0] cmd_a, cmd_b, alu_a, alu_b, alu_z, alu_flags, rsp_z, rsp_flags, acc, op_count;

    int total = 0;
    int bad   = 0;

    // Reference state: accumulator, completed-op count and last issued ALU inputs.
    logic [7:0] m_acc [2];
    int         m_cnt [2];
    logic [3:0] m_ctl [2];
    logic [7:0] m_a   [2];
    logic [7:0] m_b   [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU behaviour: returns {z, flags}; flags = {5'b0, zero, negative, carry/borrow}.
    function automatic logic [15:0] alu_ref(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0]  w;
        logic [15:0] p;
        logic [7:0]  z;
        logic        c;
        z = 8'h00;
        c = 1'b0;
        case (op)
            4'h0: begin w = {1'b0, a} + {1'b0, b}; z = w[7:0]; c = w[8]; end
            4'h1: begin w = {1'b0, a} - {1'b0, b}; z = w[7:0]; c = w[8]; end
            4'h2: begin p = {a, a} >> b[2:0]; z = p[7:0]; end
            4'h4: begin p = a * b; z = p[7:0]; c = |p[15:8]; end
            4'h6: z = a ^ b;
            default: z = 8'h00;
        endcase
        return {z, 5'b00000, (z == 8'h00), z[7], c};
    endfunction

    function automatic logic ref_legal(input logic [3:0] op);
        return op inside {4'h0, 4'h1, 4'h2, 4'h4, 4'h6};
    endfunction

    // Sibling ALU instances fed by each issuer.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            {alu_z[i], alu_flags[i]} = alu_ref(alu_ctl[i], alu_a[i], alu_b[i]);
        end
    end

    assign op_count[1][7:2] = 6'b000000;

    alu_op_issuer #(.SETTLE_CYCLES(S0), .CNT_W(8)) dut0 (
        .clk(clk), .rst(rst[0]), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
        .cmd_op(cmd_op[0]), .cmd_a(cmd_a[0]), .cmd_b(cmd_b[0]), .cmd_use_acc(cmd_use_acc[0]),
        .alu_ctl(alu_ctl[0]), .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_z(alu_z[0]),
        .alu_flags(alu_flags[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_z(rsp_z[0]), .rsp_flags(rsp_flags[0]), .rsp_err(rsp_err[0]), .acc(acc[0]),
        .op_count(op_count[0])
    );

    alu_op_issuer #(.SETTLE_CYCLES(S1), .CNT_W(2)) dut1 (
        .clk(clk), .rst(rst[1]), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
        .cmd_op(cmd_op[1]), .cmd_a(cmd_a[1]), .cmd_b(cmd_b[1]), .cmd_use_acc(cmd_use_acc[1]),
        .alu_ctl(alu_ctl[1]), .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_z(alu_z[1]),
        .alu_flags(alu_flags[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_z(rsp_z[1]), .rsp_flags(rsp_flags[1]), .rsp_err(rsp_err[1]), .acc(acc[1]),
        .op_count(op_count[1][1:0])
    );

    function automatic int settle_of(input int sel);
        return (sel == 0) ? S0 : S1;
    endfunction

    function automatic logic [7:0] exp_cnt(input int sel);
        return (sel == 0) ? 8'(m_cnt[sel] % 256) : 8'(m_cnt[sel] % 4);
    endfunction

    task automatic model_reset(input int sel);
        m_acc[sel] = 8'h00;
        m_cnt[sel] = 0;
        m_ctl[sel] = 4'h0;
        m_a[sel]   = 8'h00;
        m_b[sel]   = 8'h00;
    endtask

    // Full transaction: accept, settle, response (optionally stalled 'hold' cycles with a stray command), release.
    task automatic issue(input int sel, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic use_acc, input int hold);
        logic [15:0] zf;
        logic [7:0]  ea, ez, ef;
        logic        legal;
        int          n;
        int          exp_n;
        @(negedge clk);
        total++; if (cmd_ready[sel] !== 1'b1) begin bad++; $display("FAIL cmd_ready_idle[%0d] got=%b exp=1", sel, cmd_ready[sel]); end
        legal = ref_legal(op);
        ea    = use_acc ? m_acc[sel] : a;
        zf    = alu_ref(op, ea, b);
        ez    = zf[15:8];
        ef    = zf[7:0];
        rsp_ready[sel]   = (hold == 0);
        cmd_valid[sel]   = 1'b1;
        cmd_op[sel]      = op;
        cmd_a[sel]       = a;
        cmd_b[sel]       = b;
        cmd_use_acc[sel] = use_acc;
        @(posedge clk);
        #1;
        cmd_valid[sel] = 1'b0;
        cmd_a[sel]     = 8'($urandom);
        cmd_b[sel]     = 8'($urandom);
        @(negedge clk);
        if (legal) begin
            m_ctl[sel] = op;
            m_a[sel]   = ea;
            m_b[sel]   = b;
        end
        total++; if (alu_ctl[sel] !== m_ctl[sel]) begin bad++; $display("FAIL alu_ctl[%0d] got=%h exp=%h", sel, alu_ctl[sel], m_ctl[sel]); end
        total++; if (alu_a[sel] !== m_a[sel]) begin bad++; $display("FAIL alu_a[%0d] got=%h exp=%h", sel, alu_a[sel], m_a[sel]); end
        total++; if (alu_b[sel] !== m_b[sel]) begin bad++; $display("FAIL alu_b[%0d] got=%h exp=%h", sel, alu_b[sel], m_b[sel]); end
        // n counts edges after the accepting edge until rsp_valid is seen.
        n = 0;
        while (rsp_valid[sel] !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        exp_n = legal ? settle_of(sel) : 0;
        total++; if (n !== exp_n) begin bad++; $display("FAIL rsp_latency[%0d] got=%0d exp=%0d op=%h", sel, n, exp_n, op); end
        if (legal) begin
            m_acc[sel] = ez;
            m_cnt[sel] = m_cnt[sel] + 1;
        end else begin
            ez = 8'h00;
            ef = 8'h00;
        end
        total++; if (rsp_z[sel] !== ez) begin bad++; $display("FAIL rsp_z[%0d] got=%h exp=%h op=%h", sel, rsp_z[sel], ez, op); end
        total++; if (rsp_flags[sel] !== ef) begin bad++; $display("FAIL rsp_flags[%0d] got=%h exp=%h", sel, rsp_flags[sel], ef); end
        total++; if (rsp_err[sel] !== !legal) begin bad++; $display("FAIL rsp_err[%0d] got=%b exp=%b", sel, rsp_err[sel], !legal); end
        total++; if (acc[sel] !== m_acc[sel]) begin bad++; $display("FAIL acc[%0d] got=%h exp=%h", sel, acc[sel], m_acc[sel]); end
        total++; if (op_count[sel] !== exp_cnt(sel)) begin bad++; $display("FAIL op_count[%0d] got=%0d exp=%0d", sel, op_count[sel], exp_cnt(sel)); end
        total++; if (cmd_ready[sel] !== 1'b0) begin bad++; $display("FAIL cmd_ready_busy[%0d] got=%b exp=0", sel, cmd_ready[sel]); end
        for (int k = 0; k < hold; k++) begin
            cmd_valid[sel]   = (k == 1);
            cmd_op[sel]      = OP_ADD;
            cmd_a[sel]       = ~m_a[sel];
            cmd_use_acc[sel] = 1'b0;
            @(negedge clk);
            total++; if (rsp_valid[sel] !== 1'b1 || rsp_z[sel] !== ez || rsp_flags[sel] !== ef || rsp_err[sel] !== !legal || cmd_ready[sel] !== 1'b0) begin
                bad++; $display("FAIL rsp_hold[%0d] got=%b/%h/%h/%b/%b exp=1/%h/%h/%b/0", sel, rsp_valid[sel], rsp_z[sel], rsp_flags[sel], rsp_err[sel], cmd_ready[sel], ez, ef, !legal);
            end
        end
        cmd_valid[sel] = 1'b0;
        rsp_ready[sel] = 1'b1;
        @(negedge clk);
        total++; if (rsp_valid[sel] !== 1'b0 || cmd_ready[sel] !== 1'b1) begin
            bad++; $display("FAIL rsp_release[%0d] got=%b/%b exp=0/1", sel, rsp_valid[sel], cmd_ready[sel]);
        end
        total++; if (alu_a[sel] !== m_a[sel] || op_count[sel] !== exp_cnt(sel)) begin
            bad++; $display("FAIL no_stray_accept[%0d] got=%h/%0d exp=%h/%0d", sel, alu_a[sel], op_count[sel], m_a[sel], exp_cnt(sel));
        end
    endtask

    task automatic test_reset(input int sel);
        rst[sel] = 1'b1;
        cmd_valid[sel] = 1'b0;
        rsp_ready[sel] = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst[sel] = 1'b0;
        model_reset(sel);
        total++; if (cmd_ready[sel] !== 1'b1 || rsp_valid[sel] !== 1'b0) begin
            bad++; $display("FAIL reset_handshake[%0d] got=%b/%b exp=1/0", sel, cmd_ready[sel], rsp_valid[sel]);
        end
        total++; if (alu_ctl[sel] !== 4'h0 || alu_a[sel] !== 8'h00 || alu_b[sel] !== 8'h00) begin
            bad++; $display("FAIL reset_alu[%0d] got=%h/%h/%h exp=0/00/00", sel, alu_ctl[sel], alu_a[sel], alu_b[sel]);
        end
        total++; if (rsp_z[sel] !== 8'h00 || rsp_flags[sel] !== 8'h00 || rsp_err[sel] !== 1'b0 || acc[sel] !== 8'h00 || op_count[sel] !== 8'h00) begin
            bad++; $display("FAIL reset_regs[%0d] got=%h/%h/%b/%h/%h exp=00/00/0/00/00", sel, rsp_z[sel], rsp_flags[sel], rsp_err[sel], acc[sel], op_count[sel]);
        end
    endtask

    task automatic test_add_sub();
        issue(0, OP_ADD, 8'h05, 8'h03, 1'b0, 0);
        total++; if (acc[0] !== 8'h08 || op_count[0] !== 8'd1) begin bad++; $display("FAIL add_result got=%h/%0d exp=08/1", acc[0], op_count[0]); end
        issue(0, OP_SUB, 8'hEE, 8'h08, 1'b1, 0);
        total++; if (rsp_z[0] !== 8'h00 || rsp_flags[0][2] !== 1'b1 || acc[0] !== 8'h00) begin
            bad++; $display("FAIL sub_chain got=%h/%b/%h exp=00/1/00", rsp_z[0], rsp_flags[0][2], acc[0]);
        end
    endtask

    task automatic test_stall();
        issue(0, OP_MUL, 8'($urandom), 8'($urandom), 1'b0, 5);
    endtask

    task automatic test_illegal();
        issue(0, 4'hF, 8'h12, 8'h34, 1'b0, 0);
        total++; if (alu_ctl[0] !== OP_MUL || op_count[0] !== 8'd3) begin
            bad++; $display("FAIL illegal_side_effect got=%h/%0d exp=4/3", alu_ctl[0], op_count[0]);
        end
    endtask

    task automatic test_random(input int sel, input int iters);
        logic [3:0] op;
        logic [3:0] legal_ops [5];
        legal_ops = '{OP_ADD, OP_SUB, OP_ROTR, OP_MUL, OP_LOGIC};
        for (int i = 0; i < iters; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                op = 4'($urandom_range(0, 15));
                while (ref_legal(op)) op = 4'($urandom_range(0, 15));
            end else begin
                op = legal_ops[$urandom_range(0, 4)];
            end
            issue(sel, op, 8'($urandom), 8'($urandom), 1'($urandom), $urandom_range(0, 2));
        end
    endtask

    task automatic test_reset_in_resp();
        @(negedge clk);
        rsp_ready[0] = 1'b0;
        cmd_valid[0] = 1'b1;
        cmd_op[0]    = 4'hB;
        @(posedge clk);
        #1;
        cmd_valid[0] = 1'b0;
        @(negedge clk);
        total++; if (rsp_valid[0] !== 1'b1 || rsp_err[0] !== 1'b1) begin bad++; $display("FAIL resp_pending got=%b/%b exp=1/1", rsp_valid[0], rsp_err[0]); end
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        rsp_ready[0] = 1'b1;
        model_reset(0);
        total++; if (rsp_valid[0] !== 1'b0 || rsp_err[0] !== 1'b0 || cmd_ready[0] !== 1'b1 || acc[0] !== 8'h00 || op_count[0] !== 8'h00 || alu_a[0] !== 8'h00) begin
            bad++; $display("FAIL reset_in_resp got=%b/%b/%b/%h/%h/%h exp=0/0/1/00/00/00", rsp_valid[0], rsp_err[0], cmd_ready[0], acc[0], op_count[0], alu_a[0]);
        end
    endtask

    task automatic test_reset_mid_drive();
        issue(1, OP_ADD, 8'h11, 8'h22, 1'b0, 0);
        @(negedge clk);
        cmd_valid[1] = 1'b1;
        cmd_op[1]    = OP_ADD;
        cmd_a[1]     = 8'h40;
        cmd_b[1]     = 8'h01;
        cmd_use_acc[1] = 1'b0;
        @(posedge clk);
        #1;
        cmd_valid[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++; if (rsp_valid[1] !== 1'b0 || cmd_ready[1] !== 1'b0) begin bad++; $display("FAIL mid_drive got=%b/%b exp=0/0", rsp_valid[1], cmd_ready[1]); end
        rst[1] = 1'b1;
        @(negedge clk);
        rst[1] = 1'b0;
        model_reset(1);
        total++; if (cmd_ready[1] !== 1'b1 || rsp_valid[1] !== 1'b0 || acc[1] !== 8'h00 || op_count[1] !== 8'h00) begin
            bad++; $display("FAIL reset_mid_drive got=%b/%b/%h/%0d exp=1/0/00/0", cmd_ready[1], rsp_valid[1], acc[1], op_count[1]);
        end
        repeat (4) @(negedge clk);
        total++; if (rsp_valid[1] !== 1'b0 || op_count[1] !== 8'h00) begin
            bad++; $display("FAIL discarded_op got=%b/%0d exp=0/0", rsp_valid[1], op_count[1]);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] want [4];
        want = '{8'd1, 8'd2, 8'd3, 8'd0};
        for (int k = 0; k < 4; k++) begin
            issue(1, OP_LOGIC, 8'($urandom), 8'($urandom), 1'b0, 0);
            total++; if (op_count[1] !== want[k]) begin bad++; $display("FAIL count_wrap[%0d] got=%0d exp=%0d", k, op_count[1], want[k]); end
        end
    endtask

    initial begin
        rst = 2'b11; cmd_valid = 2'b00; rsp_ready = 2'b11; cmd_use_acc = 2'b00;
        cmd_op = '0; cmd_a = '0; cmd_b = '0;
        model_reset(0);
        model_reset(1);
        test_reset(0);
        test_reset(1);
        test_add_sub();
        test_stall();
        test_illegal();
        test_random(0, 30);
        test_reset_in_resp();
        test_reset_mid_drive();
        test_back_to_back();
        test_random(1, 20);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
